// File: rtl/ahb_s2m_s3.sv
// AHB slave-to-master return-path mux for three slaves plus an internal default
// slave that answers unmapped NONSEQ/SEQ transfers with the two-cycle ERROR response.
module ahb_s2m_s3 #(
    parameter logic [31:0] P_RDATA_DEFAULT = 32'h0000_0000
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL_0,
    input  logic        HSEL_1,
    input  logic        HSEL_2,
    input  logic [1:0]  HTRANS,
    input  logic        HREADY_0,
    input  logic        HREADY_1,
    input  logic        HREADY_2,
    input  logic [1:0]  HRESP_0,
    input  logic [1:0]  HRESP_1,
    input  logic [1:0]  HRESP_2,
    input  logic [31:0] HRDATA_0,
    input  logic [31:0] HRDATA_1,
    input  logic [31:0] HRDATA_2,
    output logic        HREADY,
    output logic [1:0]  HRESP,
    output logic [31:0] HRDATA
);

    typedef enum logic [3:0] {
        SEL_S0  = 4'b0001,
        SEL_S1  = 4'b0010,
        SEL_S2  = 4'b0100,
        SEL_DEF = 4'b1000
    } sel_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } state_t;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    sel_t   w_sel_a;
    sel_t   r_sel_d;
    state_t r_state;
    logic   w_unmapped_active;
    logic   w_def_ready;
    logic   [1:0] w_def_resp;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_sel_a = SEL_DEF;
        if (HSEL_0)
            w_sel_a = SEL_S0;
        else if (HSEL_1)
            w_sel_a = SEL_S1;
        else if (HSEL_2)
            w_sel_a = SEL_S2;
    end

    assign w_unmapped_active = (w_sel_a == SEL_DEF) && HTRANS[1];

    // HREADY only reaches registers here, so the combinational ready path never loops.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_sel_d <= SEL_DEF;
            r_state <= ST_IDLE;
        end else begin
            if (HREADY)
                r_sel_d <= w_sel_a;
            case (r_state)
                ST_IDLE: if (HREADY && w_unmapped_active) r_state <= ST_ERR1;
                ST_ERR1: r_state <= ST_ERR2;
                ST_ERR2: r_state <= w_unmapped_active ? ST_ERR1 : ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_def_ready = (r_state != ST_ERR1);
    assign w_def_resp  = (r_state == ST_IDLE) ? RESP_OKAY : RESP_ERROR;

    always_comb begin
        HREADY = w_def_ready;
        HRESP  = w_def_resp;
        HRDATA = P_RDATA_DEFAULT;
        case (r_sel_d)
            SEL_S0: begin
                HREADY = HREADY_0;
                HRESP  = HRESP_0;
                HRDATA = HRDATA_0;
            end
            SEL_S1: begin
                HREADY = HREADY_1;
                HRESP  = HRESP_1;
                HRDATA = HRDATA_1;
            end
            SEL_S2: begin
                HREADY = HREADY_2;
                HRESP  = HRESP_2;
                HRDATA = HRDATA_2;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ahb_s2m_s3.sv
// Scoreboard bench for ahb_s2m_s3: each driven cycle queues the expected
// {HREADY, HRESP, HRDATA}; a negedge monitor pops and compares.
module tb_ahb_s2m_s3;

    localparam logic [31:0] D0 = 32'hC0C0_0000;
    localparam logic [31:0] D1 = 32'hA5A5_0001;
    localparam logic [31:0] D2 = 32'hB2B2_0002;
    localparam logic [31:0] DEF = 32'h0000_0000;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        HSEL_0 = 1'b0, HSEL_1 = 1'b0, HSEL_2 = 1'b0;
    logic [1:0]  HTRANS = 2'b00;
    logic        HREADY_0 = 1'b1, HREADY_1 = 1'b1, HREADY_2 = 1'b1;
    logic [1:0]  HRESP_0 = 2'b00, HRESP_1 = 2'b00, HRESP_2 = 2'b00;
    logic [31:0] HRDATA_0 = D0, HRDATA_1 = D1, HRDATA_2 = D2;
    logic        HREADY;
    logic [1:0]  HRESP;
    logic [31:0] HRDATA;

    typedef struct {
        string       tag;
        logic [34:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    ahb_s2m_s3 #(.P_RDATA_DEFAULT(DEF)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .HSEL_0(HSEL_0), .HSEL_1(HSEL_1), .HSEL_2(HSEL_2),
        .HTRANS(HTRANS),
        .HREADY_0(HREADY_0), .HREADY_1(HREADY_1), .HREADY_2(HREADY_2),
        .HRESP_0(HRESP_0), .HRESP_1(HRESP_1), .HRESP_2(HRESP_2),
        .HRDATA_0(HRDATA_0), .HRDATA_1(HRDATA_1), .HRDATA_2(HRDATA_2),
        .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [34:0] got, input logic [34:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got rdy=%b resp=%b data=%h, expected rdy=%b resp=%b data=%h",
                     tag, got[34], got[33:32], got[31:0], exp[34], exp[33:32], exp[31:0]);
        end
    endtask

    // One bus cycle: drive inputs just after the edge, queue the outputs expected in this cycle.
    task automatic cyc(input string tag, input logic rst, input logic [2:0] sel,
                       input logic [1:0] trans, input logic [2:0] rdy, input logic [1:0] resp2,
                       input logic e_rdy, input logic [1:0] e_resp, input logic [31:0] e_data);
        exp_t e;
        @(posedge HCLK);
        #1;
        HRESET = rst;
        {HSEL_2, HSEL_1, HSEL_0} = sel;
        HTRANS = trans;
        {HREADY_2, HREADY_1, HREADY_0} = rdy;
        HRESP_2 = resp2;
        e.tag = tag;
        e.val = {e_rdy, e_resp, e_data};
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge HCLK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check(e.tag, {HREADY, HRESP, HRDATA}, e.val);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        // Reset held two cycles, then idle to unmapped space.
        cyc("rst_a",      1, 3'b000, 2'b00, 3'b111, 2'b00, 1, 2'b00, DEF);
        cyc("rst_b",      1, 3'b000, 2'b00, 3'b111, 2'b00, 1, 2'b00, DEF);
        cyc("idle_a",     0, 3'b000, 2'b00, 3'b111, 2'b00, 1, 2'b00, DEF);
        cyc("idle_b",     0, 3'b000, 2'b00, 3'b111, 2'b00, 1, 2'b00, DEF);
        // Read from S1.
        cyc("s1_addr",    0, 3'b010, 2'b10, 3'b111, 2'b00, 1, 2'b00, DEF);
        cyc("s1_data",    0, 3'b000, 2'b00, 3'b111, 2'b00, 1, 2'b00, D1);
        cyc("s1_after",   0, 3'b000, 2'b00, 3'b111, 2'b00, 1, 2'b00, DEF);
        // S2 with three wait states; pipelined S0 address captured only on the ready edge.
        cyc("s2_addr",    0, 3'b100, 2'b10, 3'b111, 2'b00, 1, 2'b00, DEF);
        cyc("s2_wait1",   0, 3'b001, 2'b10, 3'b011, 2'b00, 0, 2'b00, D2);
        cyc("s2_wait2",   0, 3'b001, 2'b10, 3'b011, 2'b00, 0, 2'b00, D2);
        cyc("s2_wait3",   0, 3'b001, 2'b10, 3'b011, 2'b00, 0, 2'b00, D2);
        cyc("s2_done",    0, 3'b001, 2'b10, 3'b111, 2'b00, 1, 2'b00, D2);
        cyc("s0_data",    0, 3'b000, 2'b00, 3'b111, 2'b00, 1, 2'b00, D0);
        // Unmapped NONSEQ then SEQ: back-to-back two-cycle ERROR responses.
        cyc("um_addr",    0, 3'b000, 2'b10, 3'b111, 2'b00, 1, 2'b00, DEF);
        cyc("um_err1a",   0, 3'b000, 2'b11, 3'b111, 2'b00, 0, 2'b01, DEF);
        cyc("um_err2a",   0, 3'b000, 2'b11, 3'b111, 2'b00, 1, 2'b01, DEF);
        cyc("um_err1b",   0, 3'b000, 2'b00, 3'b111, 2'b00, 0, 2'b01, DEF);
        cyc("um_err2b",   0, 3'b000, 2'b00, 3'b111, 2'b00, 1, 2'b01, DEF);
        cyc("um_idle",    0, 3'b000, 2'b00, 3'b111, 2'b00, 1, 2'b00, DEF);
        // BUSY/IDLE to unmapped space stay zero-wait OKAY.
        cyc("busy_a",     0, 3'b000, 2'b01, 3'b111, 2'b00, 1, 2'b00, DEF);
        cyc("busy_b",     0, 3'b000, 2'b01, 3'b111, 2'b00, 1, 2'b00, DEF);
        cyc("busy_c",     0, 3'b000, 2'b00, 3'b111, 2'b00, 1, 2'b00, DEF);
        // S2 RETRY passes through while an unmapped NONSEQ is pipelined behind it.
        cyc("rty_addr",   0, 3'b100, 2'b10, 3'b111, 2'b00, 1, 2'b00, DEF);
        cyc("rty_data",   0, 3'b000, 2'b10, 3'b111, 2'b10, 1, 2'b10, D2);
        // Reset lands at the end of ERR1; the next cycle must be IDLE.
        cyc("rst_err1",   1, 3'b000, 2'b00, 3'b111, 2'b00, 0, 2'b01, DEF);
        cyc("post_rst",   0, 3'b000, 2'b00, 3'b111, 2'b00, 1, 2'b00, DEF);
        // Multiple selects: lowest index wins.
        cyc("pri02_addr", 0, 3'b101, 2'b10, 3'b111, 2'b00, 1, 2'b00, DEF);
        cyc("pri02_data", 0, 3'b000, 2'b00, 3'b111, 2'b00, 1, 2'b00, D0);
        cyc("pri12_addr", 0, 3'b110, 2'b10, 3'b111, 2'b00, 1, 2'b00, DEF);
        cyc("pri12_data", 0, 3'b000, 2'b00, 3'b111, 2'b00, 1, 2'b00, D1);
        @(negedge HCLK);
        @(negedge HCLK);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
